// File: rtl/xled_pkg.sv
// xled_pkg: shared definitions for the LED peripheral.
//   led_reg_e  - local register offsets (LED_CTRL .. LED_TGL)
//   led_mode_e - CTRL[1:0] mode encodings
//   LED_CTRL_EN_BIT, LED_STATUS_PHASE_BIT, LED_DUTY_W - field positions/widths
package xled_pkg;

    typedef enum logic [2:0] {
        LED_CTRL   = 3'd0,
        LED_VALUE  = 3'd1,
        LED_PERIOD = 3'd2,
        LED_DUTY   = 3'd3,
        LED_STATUS = 3'd4,
        LED_SET    = 3'd5,
        LED_CLR    = 3'd6,
        LED_TGL    = 3'd7
    } led_reg_e;

    typedef enum logic [1:0] {
        LED_MODE_STATIC = 2'd0,
        LED_MODE_BLINK  = 2'd1,
        LED_MODE_PWM    = 2'd2,
        LED_MODE_RSVD   = 2'd3
    } led_mode_e;

    localparam int LED_CTRL_EN_BIT      = 2;
    localparam int LED_STATUS_PHASE_BIT = 8;
    localparam int LED_DUTY_W           = 8;

endpackage

// File: rtl/xled_presc.sv
// xled_presc: reloadable down-counter prescaler.
//   clk, rst_n - clock, async active-low reset
//   en         - count enable; while low the counter sits at the reload value
//   load       - force reload this cycle (suppresses tick)
//   reload     - reload value; tick period is reload+1 cycles
//   cnt        - current count (for status/debug)
//   tick       - one-cycle pulse when the count reaches zero while enabled
module xled_presc #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] reload,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero;

    assign zero = (cnt_q == '0);
    assign tick = en & ~load & zero;
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (load || !en || zero) begin
            cnt_d = reload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xled_ctrl.sv
// xled_ctrl: memory-mapped LED peripheral (static / blink / PWM dimming).
//   clk, rst_n - clock, async active-low reset
//   sel, we    - decoder block select and CPU write enable (write = sel & we)
//   addr       - local register offset
//   data_in    - write data
//   data_out   - combinational read data, 0 when sel=0
//   led        - registered LED pins
// Build option: define LED_PWM_EN to implement PWM mode, the DUTY register
// and the STATUS pwm counter. Without it, mode 2 acts as static, DUTY and
// STATUS[7:0] read 0 and no PWM counter/comparator exists.
module xled_ctrl
    import xled_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LED_W      = 8,
    parameter int LED_ADDR_W = 3,
    parameter int CNT_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  we,
    input  logic [LED_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic [LED_W-1:0]      led
);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [LED_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             phase_q, phase_d;
    logic [LED_W-1:0] led_q, led_d;
`ifdef LED_PWM_EN
    logic [LED_DUTY_W-1:0] duty_q, duty_d;
    logic [LED_DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
`endif

    led_reg_e         reg_sel;
    led_mode_e        mode;
    logic             wr, load, enable, tick;
    logic [LED_W-1:0] wdata_led;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] presc_cnt;

    assign reg_sel   = led_reg_e'(3'(addr));
    assign wr        = sel & we;
    assign wdata_led = data_in[LED_W-1:0];
    assign enable    = ctrl_q[LED_CTRL_EN_BIT];
    assign mode      = led_mode_e'(ctrl_q[1:0]);

    // CTRL and PERIOD writes restart the timebase; the new PERIOD is used
    // straight away rather than the stale register value.
    assign load   = wr && ((reg_sel == LED_CTRL) || (reg_sel == LED_PERIOD));
    assign reload = (wr && (reg_sel == LED_PERIOD)) ? data_in[CNT_W-1:0] : period_q;

    xled_presc #(
        .CNT_W (CNT_W)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (enable),
        .load   (load),
        .reload (reload),
        .cnt    (presc_cnt),
        .tick   (tick)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        value_d  = value_q;
        period_d = period_q;
`ifdef LED_PWM_EN
        duty_d   = duty_q;
`endif
        if (wr) begin
            case (reg_sel)
                LED_CTRL:   ctrl_d   = data_in[2:0];
                LED_VALUE:  value_d  = wdata_led;
                LED_PERIOD: period_d = data_in[CNT_W-1:0];
                LED_DUTY: begin
`ifdef LED_PWM_EN
                    duty_d = data_in[LED_DUTY_W-1:0];
`endif
                end
                LED_SET:    value_d  = value_q | wdata_led;
                LED_CLR:    value_d  = value_q & ~wdata_led;
                LED_TGL:    value_d  = value_q ^ wdata_led;
                default:    ;
            endcase
        end
    end

    // tick is already masked by load, so a restart always wins over a step.
    always_comb begin
        phase_d = phase_q;
`ifdef LED_PWM_EN
        pwm_cnt_d = pwm_cnt_q;
`endif
        if (load || !enable) begin
            phase_d = 1'b0;
`ifdef LED_PWM_EN
            pwm_cnt_d = '0;
`endif
        end else if (tick) begin
            phase_d = ~phase_q;
`ifdef LED_PWM_EN
            pwm_cnt_d = pwm_cnt_q + LED_DUTY_W'(1);
`endif
        end
    end

    always_comb begin
        led_d = '0;
        if (enable) begin
            case (mode)
                LED_MODE_BLINK: led_d = phase_q ? value_q : '0;
`ifdef LED_PWM_EN
                LED_MODE_PWM:   led_d = (pwm_cnt_q < duty_q) ? value_q : '0;
`endif
                default:        led_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            value_q  <= '0;
            period_q <= '0;
            phase_q  <= 1'b0;
            led_q    <= '0;
`ifdef LED_PWM_EN
            duty_q    <= '0;
            pwm_cnt_q <= '0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            value_q  <= value_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
`ifdef LED_PWM_EN
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
`endif
        end
    end

    assign led = led_q;

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (reg_sel)
                LED_CTRL:   data_out[2:0]       = ctrl_q;
                LED_PERIOD: data_out[CNT_W-1:0] = period_q;
                LED_DUTY: begin
`ifdef LED_PWM_EN
                    data_out[LED_DUTY_W-1:0] = duty_q;
`endif
                end
                LED_STATUS: begin
                    data_out[LED_STATUS_PHASE_BIT] = phase_q;
`ifdef LED_PWM_EN
                    data_out[LED_DUTY_W-1:0] = pwm_cnt_q;
`endif
                end
                default:    data_out[LED_W-1:0] = value_q;
            endcase
        end
    end

    // Upper write-data bits and the raw count have no register behind them.
    logic unused_bits;
    assign unused_bits = ^{data_in[DATA_W-1:CNT_W], presc_cnt};

endmodule

// File: tb/tb_xled_ctrl.sv
module tb_xled_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    xled_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timebase tracked as "cycles since restart" and
    // "ticks since restart"; phase and pwm count derive from the tick total.
    logic [2:0]  m_ctrl;
    logic [7:0]  m_value;
    logic [23:0] m_period;
    logic [7:0]  m_duty;
    int unsigned m_age;
    int unsigned m_ticks;
    logic [7:0]  m_led;

    task automatic m_reset();
        m_ctrl = 0; m_value = 0; m_period = 0; m_duty = 0;
        m_age = 0; m_ticks = 0; m_led = 0;
    endtask

    function automatic logic [31:0] m_read(input logic s, input logic [2:0] a);
        logic [31:0] r;
        r = 0;
        if (s) begin
            case (a)
                3'd0: r = 32'(m_ctrl);
                3'd2: r = 32'(m_period);
                3'd3: begin
`ifdef LED_PWM_EN
                    r = 32'(m_duty);
`endif
                end
                3'd4: begin
                    r = (m_ticks % 2) << 8;
`ifdef LED_PWM_EN
                    r = r | (m_ticks % 256);
`endif
                end
                default: r = 32'(m_value);
            endcase
        end
        return r;
    endfunction

    task automatic m_step(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d);
        logic       en, ld, tk;
        logic [1:0] md;
        logic [7:0] nl;
        en = m_ctrl[2];
        md = m_ctrl[1:0];
        ld = s && w && (a == 3'd0 || a == 3'd2);
        nl = m_value;
        if (!en) nl = 0;
        else if (md == 2'd1 && (m_ticks % 2) == 0) nl = 0;
`ifdef LED_PWM_EN
        else if (md == 2'd2 && (m_ticks % 256) >= 32'(m_duty)) nl = 0;
`endif
        tk = en && !ld && (m_age == 32'(m_period));
        if (ld || !en) begin
            m_age = 0; m_ticks = 0;
        end else if (tk) begin
            m_age = 0; m_ticks = m_ticks + 1;
        end else begin
            m_age = m_age + 1;
        end
        if (s && w) begin
            case (a)
                3'd0: m_ctrl   = d[2:0];
                3'd1: m_value  = d[7:0];
                3'd2: m_period = d[23:0];
                3'd3: begin
`ifdef LED_PWM_EN
                    m_duty = d[7:0];
`endif
                end
                3'd5: m_value = m_value | d[7:0];
                3'd6: m_value = m_value & ~d[7:0];
                3'd7: m_value = m_value ^ d[7:0];
                default: ;
            endcase
        end
        m_led = nl;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check read data, clock, check led.
    task automatic cyc(input logic s, input logic w, input logic [2:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        sel = s; we = w; addr = a; data_in = d;
        #1;
        rd = data_out;
        chk("rdata", data_out, m_read(s, a));
        @(posedge clk);
        m_step(s, w, a, d);
        #1;
        chk("led", 32'(led), 32'(m_led));
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] rd;
        cyc(1'b1, 1'b1, a, d, rd);
    endtask

    task automatic idle(input logic [2:0] a, output logic [31:0] rd);
        cyc(1'b1, 1'b0, a, 32'h0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt;
        logic        s, w;
        logic [2:0]  a;
        logic [31:0] d;

        rst_n = 1'b0; sel = 0; we = 0; addr = 0; data_in = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_led", 32'(led), 32'h0);

        // static mode and SET/CLR/TGL
        wr(3'd0, 32'h4);
        wr(3'd1, 32'hA5);
        idle(3'd1, rd); chk("static_value", 32'(led), 32'hA5);
        wr(3'd5, 32'h0F);
        idle(3'd5, rd); chk("set", 32'(led), 32'hAF);
        wr(3'd6, 32'hA0);
        idle(3'd6, rd); chk("clr", 32'(led), 32'h0F);
        wr(3'd7, 32'hFF);
        idle(3'd7, rd); chk("tgl", 32'(led), 32'hF0);
        chk("tgl_read", rd, 32'hF0);

        // asynchronous reset mid-cycle, no clock edge in between
        sel = 1; we = 0; addr = 3'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_read", data_out, 32'h0);
        m_reset();
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            #1 chk("rst_regs", data_out, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // blink: PERIOD=3 gives 4-cycle half periods
        wr(3'd2, 32'd3);
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h5);
        for (int k = 1; k <= 12; k++) begin
            idle(3'd4, rd);
            chk("blink_led", 32'(led), (k >= 5 && k <= 8) ? 32'hFF : 32'h0);
        end
        wr(3'd0, 32'h1);
        idle(3'd0, rd); chk("blink_disable", 32'(led), 32'h0);

`ifdef LED_PWM_EN
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd64);
        wr(3'd1, 32'h01);
        wr(3'd0, 32'h6);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            idle(3'd4, rd);
            cnt += int'(led[0]);
        end
        chk("pwm_duty64", 32'(cnt), 32'd64);
        wr(3'd3, 32'd0);
        idle(3'd3, rd);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            idle(3'd4, rd);
            cnt += int'(led[0]);
        end
        chk("pwm_duty0", 32'(cnt), 32'd0);
`else
        wr(3'd3, 32'd64);
        wr(3'd1, 32'h3C);
        wr(3'd0, 32'h6);
        idle(3'd3, rd);
        chk("nopwm_static", 32'(led), 32'h3C);
        chk("nopwm_duty", rd, 32'h0);
`endif

        // write/tick collision
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h5);
        repeat (3) idle(3'd4, rd);
        wr(3'd2, 32'd2);
        for (int j = 1; j <= 4; j++) begin
            idle(3'd4, rd);
            chk("collide_phase", 32'(rd[8]), (j == 4) ? 32'd1 : 32'd0);
        end

        // read mux gated by sel
        wr(3'd1, 32'h5A);
        cyc(1'b0, 1'b0, 3'd1, 32'h0, rd);
        chk("sel0_read", rd, 32'h0);
        cyc(1'b0, 1'b1, 3'd1, 32'hFF, rd);
        idle(3'd1, rd); chk("sel0_nowrite", rd, 32'h5A);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd2) d = d % 6;
            s = ($urandom % 8) != 0;
            w = ($urandom % 4) == 0;
            cyc(s, w, a, d, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xled_ctrl.md
Name: xled_ctrl

Overview:
- Memory-mapped LED peripheral, directly downstream of the address decoder.
- Consumes the decoder's led_sel strobe plus CPU write enable, low address bits and write data; drives the board LED pins.
- Supports three modes: static pattern, prescaled blink, and 8-bit PWM dimming.
- Provides a combinational read-back port so the LED read path can be muxed into the decoder's read data.

Parameters:
- DATA_W, 32, CPU data bus width.
- LED_W, 8, number of LED output pins (≤ DATA_W).
- LED_ADDR_W, 3, local register address width (8 registers).
- CNT_W, 24, prescaler counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  1  block select (decoder led_sel).
- we  in  1  write enable, qualified by sel.
- addr  in  LED_ADDR_W  register offset (low address bits).
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data (combinational); 0 when sel=0.
- led  out  LED_W  LED pins, registered.

Behaviour:
- Reset (rst_n=0, async): all registers, counters, phase and led go to 0; data_out is 0.
- A write happens on a rising clk edge when sel=1 and we=1. At most one write per cycle.
- Register map:
  - 0 CTRL: [1:0] mode (0 static, 1 blink, 2 PWM, 3 reserved, treated as static); [2] enable.
  - 1 VALUE: [LED_W-1:0] pattern.
  - 2 PERIOD: [CNT_W-1:0] prescaler reload.
  - 3 DUTY: [7:0].
  - 4 STATUS (read-only): [7:0] pwm_cnt, [8] phase. Writes to STATUS are ignored.
  - 5 SET: VALUE |= data. Reads return VALUE.
  - 6 CLR: VALUE &= ~data. Reads return VALUE.
  - 7 TGL: VALUE ^= data. Reads return VALUE.
- Reads: data_out is zero-extended register content, same cycle, no side effects.
- Prescaler: presc counts down from PERIOD. When presc==0 and enable=1: tick=1 for one cycle and presc reloads PERIOD. PERIOD=0 gives a tick every cycle; tick period is PERIOD+1 cycles.
- Blink: phase toggles on each tick.
- PWM: pwm_cnt increments on each tick and wraps 255→0.
- Writes to CTRL or PERIOD reload presc with the new PERIOD, clear phase and clear pwm_cnt. If such a write coincides with a tick, the write wins and no toggle/increment occurs that cycle.
- enable=0: presc, phase and pwm_cnt are held at 0/PERIOD; led is 0.
- led next-state, registered, 1-cycle latency from any state change:
  - static: VALUE.
  - blink: phase ? VALUE : 0.
  - PWM: (pwm_cnt < DUTY) ? VALUE : 0.
  - DUTY=0 is always off; DUTY=255 is on 255 of 256 ticks.
- Reset asserted mid-operation clears everything immediately, with no waiting for a clock edge.

Optional Feature:
- Macro LED_PWM_EN.
- Defined: PWM mode, DUTY register and STATUS[7:0] are implemented as above.
- Undefined:
  - mode 2 behaves as static;
  - DUTY writes are ignored and DUTY reads 0;
  - STATUS[7:0] reads 0;
  - no pwm_cnt or comparator is synthesised.

Decomposition:
- Shared xdefs.vh gets LED register offsets (LED_CTRL..LED_TGL), mode encodings (LED_MODE_STATIC/BLINK/PWM) and the CTRL enable bit index.
- One natural sub-module: xled_presc. It holds the down-counter with reload, load strobe and tick output, and is reusable for a future timer.

Test Plan:
- Reset value check: pulse rst_n low with no clk edge → led=0 and every register reads 0 immediately.
- Static mode and SET/CLR/TGL: write CTRL=0x4, VALUE=0xA5 → led=0xA5 one cycle later. Then SET 0x0F → 0xAF; CLR 0xA0 → 0x0F; TGL 0xFF → 0xF0.
- Blink timing: PERIOD=3, VALUE=0xFF, CTRL=0x5 → led alternates 0x00/0xFF every 4 cycles. STATUS[8] follows phase. Writing CTRL=0x1 (enable cleared) → led=0 next cycle.
- PWM duty: PERIOD=0, DUTY=64, VALUE=0x01, CTRL=0x6 → led[0] high exactly 64 of every 256 cycles. DUTY=0 → constantly 0.
- Write/tick collision: PERIOD=0 blink running; write PERIOD=2 on a tick cycle → no toggle that cycle, phase=0, next tick 3 cycles later.
- Read mux and macro build: sel=0 → data_out=0. Build without LED_PWM_EN, CTRL=0x6 → led=VALUE and DUTY reads 0.
